// File: rtl/aoi_sweep_if.sv
// Handshake/result bundle between an AOI sweep engine and its consumer.
// The tally signal exists only when AOI_SWEEP_TALLY_EN is defined.
interface aoi_sweep_if #(
  parameter int N_IN = 4
);
  logic              start;
  logic              hold;
  logic [N_IN-1:0]   vec_out;
  logic [N_IN/2-1:0] and_out;
  logic              aoi_out;
  logic              valid;
  logic              busy;
  logic              done;
`ifdef AOI_SWEEP_TALLY_EN
  logic [N_IN:0]     tally;
`endif

  modport master (
    output start, hold,
    input  vec_out, and_out, aoi_out, valid, busy, done
`ifdef AOI_SWEEP_TALLY_EN
    , input tally
`endif
  );

  modport slave (
    input  start, hold,
    output vec_out, and_out, aoi_out, valid, busy, done
`ifdef AOI_SWEEP_TALLY_EN
    , output tally
`endif
  );
endinterface

// File: rtl/aoi_sweep_engine.sv
// Self-running exhaustive sweep of N_IN-bit vectors through a pairwise AND-OR-INVERT.
// Define AOI_SWEEP_TALLY_EN to build the count of vectors whose AOI result is 1.
module aoi_sweep_engine #(
  parameter int N_IN        = 4,
  parameter int STEP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  aoi_sweep_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              CNT_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [N_IN-1:0]  VEC_LAST   = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN/2-1:0] and_q, and_d;
  logic              aoi_q, aoi_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef AOI_SWEEP_TALLY_EN
  logic [N_IN:0]     tally_q, tally_d;
`endif

  logic              start_acc;
  logic              dwell_end;
  logic              last_vec;
  logic [N_IN-1:0]   vec_next;
  logic [N_IN/2-1:0] and_next;
  logic              aoi_next;

  assign start_acc = (state_q == S_IDLE) && bus.start;
  assign dwell_end = (state_q == S_RUN) && !bus.hold && (dwell_q == DWELL_LAST);
  assign last_vec  = (vec_q == VEC_LAST);

  // Candidate vector for the next load and its AOI terms, so results register with it.
  assign vec_next = start_acc ? '0 : vec_q + N_IN'(1);

  generate
    for (genvar gi = 0; gi < N_IN / 2; gi++) begin : g_pair
      assign and_next[gi] = vec_next[2*gi] & vec_next[2*gi+1];
    end
  endgenerate

  assign aoi_next = ~|and_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (dwell_end && last_vec) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dwell_d = dwell_q;
    vec_d   = vec_q;
    and_d   = and_q;
    aoi_d   = aoi_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dwell_d = '0;
          vec_d   = vec_next;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        // A held cycle changes nothing, so a due load simply waits for hold to drop.
        if (!bus.hold) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (last_vec) begin
              busy_d = 1'b0;
              done_d = 1'b1;
            end else begin
              vec_d   = vec_next;
              valid_d = 1'b1;
            end
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
    if (valid_d) begin
      and_d = and_next;
      aoi_d = aoi_next;
    end
  end

`ifdef AOI_SWEEP_TALLY_EN
  // valid_d marks exactly one load per vector, so each vector counts at most once.
  always_comb begin
    tally_d = tally_q;
    if (start_acc) begin
      tally_d    = '0;
      tally_d[0] = aoi_next;
    end else if (valid_d && aoi_next) begin
      tally_d = tally_q + (N_IN + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tally_q <= '0;
    end else begin
      tally_q <= tally_d;
    end
  end

  assign bus.tally = tally_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      vec_q   <= '0;
      and_q   <= '0;
      aoi_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      vec_q   <= vec_d;
      and_q   <= and_d;
      aoi_q   <= aoi_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.vec_out = vec_q;
  assign bus.and_out = and_q;
  assign bus.aoi_out = aoi_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_aoi_sweep_engine.sv
// Bench for aoi_sweep_engine: directed table, sweep-length and reset sequences, then random stimulus vs a model.
// Two engines (dwell 1 and 2) share stimulus; tally checks are built when AOI_SWEEP_TALLY_EN is defined.
module tb_aoi_sweep_engine;

  localparam int NB = 4;

  logic clk;
  logic rst;

  aoi_sweep_if #(.N_IN(NB)) bus1 ();
  aoi_sweep_if #(.N_IN(NB)) bus2 ();

  aoi_sweep_engine #(.N_IN(NB), .STEP_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  aoi_sweep_engine #(.N_IN(NB), .STEP_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mode;   // 0 idle, 1 sweeping, 2 finished
    int eff;    // non-hold sweep cycles completed since start
    int vec;
    int tally;
    bit shown;
    bit valid;
    bit busy;
    bit done;
  } model_t;

  typedef struct {
    bit r; bit s; bit h;
    int vec; int andv; bit aoi; bit valid; bit busy; bit done;
  } row_t;

  model_t m1, m2;
  int n_vec = 0;
  int n_err = 0;

  function automatic int ref_aoi(input int v);
    for (int p = 0; p < NB / 2; p++)
      if (((v >> (2 * p)) & 3) == 3) return 0;
    return 1;
  endfunction

  function automatic int ref_and(input int v);
    int r = 0;
    for (int p = 0; p < NB / 2; p++)
      if (((v >> (2 * p)) & 3) == 3) r = r | (1 << p);
    return r;
  endfunction

  task automatic model_step(input int step_n, inout model_t m, input bit r, input bit s, input bit h);
    if (r) begin
      m.mode = 0; m.eff = 0; m.vec = 0; m.tally = 0;
      m.shown = 0; m.valid = 0; m.busy = 0; m.done = 0;
    end else begin
      case (m.mode)
        0: begin
          m.valid = 0; m.done = 0;
          if (s) begin
            m.mode = 1; m.eff = 0; m.vec = 0; m.shown = 1;
            m.valid = 1; m.busy = 1; m.tally = ref_aoi(0);
          end
        end
        1: begin
          m.valid = 0;
          if (!h) begin
            m.eff++;
            if (m.eff == (1 << NB) * step_n) begin
              m.mode = 2; m.busy = 0; m.done = 1;
            end else if (m.eff % step_n == 0) begin
              m.vec = m.eff / step_n;
              m.valid = 1;
              m.tally += ref_aoi(m.vec);
            end
          end
        end
        default: begin
          m.mode = 0; m.valid = 0; m.done = 0;
        end
      endcase
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag, input model_t m, input logic [3:0] vec,
                           input logic [1:0] andv, input logic aoi, input logic valid,
                           input logic busy, input logic done);
    check({tag, "_vec"},   32'(vec),   m.vec);
    check({tag, "_and"},   32'(andv),  m.shown ? ref_and(m.vec) : 0);
    check({tag, "_aoi"},   32'(aoi),   m.shown ? ref_aoi(m.vec) : 0);
    check({tag, "_valid"}, 32'(valid), 32'(m.valid));
    check({tag, "_busy"},  32'(busy),  32'(m.busy));
    check({tag, "_done"},  32'(done),  32'(m.done));
  endtask

  task automatic step_cyc(input bit r, input bit s, input bit h);
    rst = r;
    bus1.start = s; bus1.hold = h;
    bus2.start = s; bus2.hold = h;
    @(posedge clk);
    model_step(1, m1, r, s, h);
    model_step(2, m2, r, s, h);
    #1;
    chk_model("m1", m1, bus1.vec_out, bus1.and_out, bus1.aoi_out, bus1.valid, bus1.busy, bus1.done);
    chk_model("m2", m2, bus2.vec_out, bus2.and_out, bus2.aoi_out, bus2.valid, bus2.busy, bus2.done);
`ifdef AOI_SWEEP_TALLY_EN
    check("m1_tally", 32'(bus1.tally), m1.tally);
    check("m2_tally", 32'(bus2.tally), m2.tally);
`endif
  endtask

  row_t tbl[24];

  initial begin
    int busy_cnt;
    int b1, b2, v1, v2, d1, d2;

    //           r  s  h  vec and aoi val busy done
    tbl[0]  = '{1, 0, 0,  0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1,  0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0,  0, 0, 1, 1, 1, 0};
    tbl[3]  = '{0, 0, 0,  1, 0, 1, 1, 1, 0};
    tbl[4]  = '{0, 0, 0,  2, 0, 1, 1, 1, 0};
    tbl[5]  = '{0, 1, 0,  3, 1, 0, 1, 1, 0};
    tbl[6]  = '{0, 0, 0,  4, 0, 1, 1, 1, 0};
    tbl[7]  = '{0, 0, 0,  5, 0, 1, 1, 1, 0};
    tbl[8]  = '{0, 0, 1,  5, 0, 1, 0, 1, 0};
    tbl[9]  = '{0, 0, 1,  5, 0, 1, 0, 1, 0};
    tbl[10] = '{0, 0, 1,  5, 0, 1, 0, 1, 0};
    tbl[11] = '{0, 0, 0,  6, 0, 1, 1, 1, 0};
    tbl[12] = '{0, 0, 0,  7, 1, 0, 1, 1, 0};
    tbl[13] = '{0, 0, 0,  8, 0, 1, 1, 1, 0};
    tbl[14] = '{0, 0, 0,  9, 0, 1, 1, 1, 0};
    tbl[15] = '{0, 0, 0, 10, 0, 1, 1, 1, 0};
    tbl[16] = '{0, 0, 0, 11, 1, 0, 1, 1, 0};
    tbl[17] = '{0, 0, 0, 12, 2, 0, 1, 1, 0};
    tbl[18] = '{0, 0, 0, 13, 2, 0, 1, 1, 0};
    tbl[19] = '{0, 0, 0, 14, 2, 0, 1, 1, 0};
    tbl[20] = '{0, 0, 0, 15, 3, 0, 1, 1, 0};
    tbl[21] = '{0, 1, 0, 15, 3, 0, 0, 0, 1};
    tbl[22] = '{0, 1, 0, 15, 3, 0, 0, 0, 0};
    tbl[23] = '{0, 0, 0, 15, 3, 0, 0, 0, 0};

    rst = 1'b1;
    bus1.start = 1'b0; bus1.hold = 1'b0;
    bus2.start = 1'b0; bus2.hold = 1'b0;
    m1 = '{default: 0};
    m2 = '{default: 0};

    // Directed table on the single-dwell engine, including a 3-cycle hold at 0101.
    busy_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step_cyc(tbl[i].r, tbl[i].s, tbl[i].h);
      check($sformatf("tbl%0d_vec", i),   32'(bus1.vec_out), tbl[i].vec);
      check($sformatf("tbl%0d_and", i),   32'(bus1.and_out), tbl[i].andv);
      check($sformatf("tbl%0d_aoi", i),   32'(bus1.aoi_out), 32'(tbl[i].aoi));
      check($sformatf("tbl%0d_valid", i), 32'(bus1.valid),   32'(tbl[i].valid));
      check($sformatf("tbl%0d_busy", i),  32'(bus1.busy),    32'(tbl[i].busy));
      check($sformatf("tbl%0d_done", i),  32'(bus1.done),    32'(tbl[i].done));
      if (bus1.busy === 1'b1) busy_cnt++;
    end
    check("held_sweep_busy_cycles", busy_cnt, 19);

    // Two clean back-to-back sweeps: lengths, valid counts, done timing, tally re-count.
    step_cyc(1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      b1 = 0; b2 = 0; v1 = 0; v2 = 0; d1 = 0; d2 = 0;
      for (int c = 1; c <= 40; c++) begin
        step_cyc(0, (c == 1), 0);
        if (bus1.busy === 1'b1) b1++;
        if (bus2.busy === 1'b1) b2++;
        if (bus1.valid === 1'b1) v1++;
        if (bus2.valid === 1'b1) v2++;
        if (bus1.done === 1'b1 && d1 == 0) d1 = c;
        if (bus2.done === 1'b1 && d2 == 0) d2 = c;
      end
      check($sformatf("sweep%0d_busy1", k),  b1, 16);
      check($sformatf("sweep%0d_valid1", k), v1, 16);
      check($sformatf("sweep%0d_done1", k),  d1, 17);
      check($sformatf("sweep%0d_busy2", k),  b2, 32);
      check($sformatf("sweep%0d_valid2", k), v2, 16);
      check($sformatf("sweep%0d_done2", k),  d2, 33);
`ifdef AOI_SWEEP_TALLY_EN
      check($sformatf("sweep%0d_tally1", k), 32'(bus1.tally), 9);
      check($sformatf("sweep%0d_tally2", k), 32'(bus2.tally), 9);
`endif
    end

    // Reset mid-sweep at 0111 (together with start: reset wins), then restart from 0.
    step_cyc(0, 1, 0);
    for (int c = 0; c < 7; c++) step_cyc(0, 0, 0);
    check("pre_rst_vec", 32'(bus1.vec_out), 7);
    step_cyc(1, 1, 0);
    check("rst_vec",  32'(bus1.vec_out), 0);
    check("rst_and",  32'(bus1.and_out), 0);
    check("rst_aoi",  32'(bus1.aoi_out), 0);
    check("rst_busy", 32'(bus1.busy), 0);
    step_cyc(0, 0, 0);
    check("idle_busy", 32'(bus1.busy), 0);
    step_cyc(0, 1, 1);
    check("restart_vec",   32'(bus1.vec_out), 0);
    check("restart_valid", 32'(bus1.valid), 1);
    check("restart_busy",  32'(bus1.busy), 1);
    check("restart_aoi",   32'(bus1.aoi_out), 1);

    // Random stimulus against the model.
    for (int c = 0; c < 4000; c++) begin
      step_cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
